vrf_read_port_pipe: RTL and testbench

Per-bank VRF read port pipeline that sits directly downstream of the read-stage round-robin arbiter. It accepts one granted read request per cycle (vs, offset, readSource, instructionIndex), issues it to a fixed-latency VRF bank SRAM, and carries the request tag alongside the SRAM pipeline. Returned data goes into a response queue, and the result is handed to the consumer over a valid/ready interface. Credit accounting guarantees that no SRAM result is ever dropped when the consumer stalls.

---
 rtl/vrf_read_port_pipe.sv | 128 ++++++++++++
 tb/tb_vrf_read_port_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_read_port_pipe.sv
`default_nettype none
// ============================================================================
// vrf_read_port_pipe : per-bank VRF read port with tag pipe, response queue
// and credit flow control. Optional parity check: VRF_READ_PARITY_EN.
// Revision: 1.0
// ============================================================================
module vrf_read_port_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_req_valid,
  output logic                  io_req_ready,
  input  logic [4:0]            io_req_bits_vs,
  input  logic [4:0]            io_req_bits_offset,
  input  logic [3:0]            io_req_bits_readSource,
  input  logic [2:0]            io_req_bits_instructionIndex,
  output logic                  sram_en,
  output logic [9:0]            sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
`ifdef VRF_READ_PARITY_EN
  input  logic                  sram_rparity,
  output logic                  io_resp_bits_parityError,
`endif
  output logic                  io_resp_valid,
  input  logic                  io_resp_ready,
  output logic [DATA_WIDTH-1:0] io_resp_bits_data,
  output logic [3:0]            io_resp_bits_readSource,
  output logic [2:0]            io_resp_bits_instructionIndex
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int PW = $clog2(QUEUE_DEPTH);
`ifdef VRF_READ_PARITY_EN
  localparam int EW = DATA_WIDTH + 8;
`else
  localparam int EW = DATA_WIDTH + 7;
`endif

  logic                    req_fire;
  logic                    resp_fire;
  logic                    push;
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [3:0]              pipe_src [READ_LATENCY];
  logic [2:0]              pipe_idx [READ_LATENCY];
  logic [EW-1:0]           q_mem [QUEUE_DEPTH];
  logic [EW-1:0]           push_entry;
  logic [EW-1:0]           head;
  logic [PW-1:0]           wptr;
  logic [PW-1:0]           rptr;
  logic [CW-1:0]           count;
  logic [CW-1:0]           outstanding;

  // A pop in this cycle frees its credit immediately, so a full block still
  // sustains one accept per cycle while the consumer drains.
  assign resp_fire    = io_resp_valid & io_resp_ready;
  assign io_req_ready = reset & ((outstanding < CW'(QUEUE_DEPTH)) | resp_fire);
  assign req_fire     = io_req_valid & io_req_ready;
  assign sram_en      = req_fire;
  assign sram_addr    = {io_req_bits_vs, io_req_bits_offset};

  assign push = pipe_valid[READ_LATENCY-1];
`ifdef VRF_READ_PARITY_EN
  assign push_entry = {((^sram_rdata) != sram_rparity), pipe_src[READ_LATENCY-1],
                       pipe_idx[READ_LATENCY-1], sram_rdata};
  assign io_resp_bits_parityError = head[DATA_WIDTH+7];
`else
  assign push_entry = {pipe_src[READ_LATENCY-1], pipe_idx[READ_LATENCY-1], sram_rdata};
`endif

  assign head                          = q_mem[rptr];
  assign io_resp_bits_data             = head[DATA_WIDTH-1:0];
  assign io_resp_bits_instructionIndex = head[DATA_WIDTH+2:DATA_WIDTH];
  assign io_resp_bits_readSource       = head[DATA_WIDTH+6:DATA_WIDTH+3];
  assign io_resp_valid                 = (count != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_src[i] <= '0;
        pipe_idx[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= req_fire;
      if (req_fire) begin
        pipe_src[0] <= io_req_bits_readSource;
        pipe_idx[0] <= io_req_bits_instructionIndex;
      end
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_src[i]   <= pipe_src[i-1];
        pipe_idx[i]   <= pipe_idx[i-1];
      end
    end
  end

  // Credits cover the tag pipe too, so a push can never meet a full queue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      outstanding <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) q_mem[i] <= '0;
    end else begin
      if (push) begin
        q_mem[wptr] <= push_entry;
        wptr        <= wptr + PW'(1);
      end
      if (resp_fire) rptr <= rptr + PW'(1);
      case ({push, resp_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case ({req_fire, resp_fire})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vrf_read_port_pipe.sv
`default_nettype none
// Scoreboard bench for vrf_read_port_pipe (default parameters; parity
// cases run when VRF_READ_PARITY_EN is defined).
module tb_vrf_read_port_pipe;
  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_req_valid = 1'b0;
  logic        io_req_ready;
  logic [4:0]  io_req_bits_vs = '0;
  logic [4:0]  io_req_bits_offset = '0;
  logic [3:0]  io_req_bits_readSource = '0;
  logic [2:0]  io_req_bits_instructionIndex = '0;
  logic        sram_en;
  logic [9:0]  sram_addr;
  logic [31:0] sram_rdata;
  logic        sram_rparity;
  logic        io_resp_valid;
  logic        io_resp_ready = 1'b0;
  logic [31:0] io_resp_bits_data;
  logic [3:0]  io_resp_bits_readSource;
  logic [2:0]  io_resp_bits_instructionIndex;
  logic        io_resp_bits_parityError;

  vrf_read_port_pipe #(.DATA_WIDTH(32), .READ_LATENCY(LAT), .QUEUE_DEPTH(4)) dut (
    .clock(clock),
    .reset(reset),
    .io_req_valid(io_req_valid),
    .io_req_ready(io_req_ready),
    .io_req_bits_vs(io_req_bits_vs),
    .io_req_bits_offset(io_req_bits_offset),
    .io_req_bits_readSource(io_req_bits_readSource),
    .io_req_bits_instructionIndex(io_req_bits_instructionIndex),
    .sram_en(sram_en),
    .sram_addr(sram_addr),
    .sram_rdata(sram_rdata),
`ifdef VRF_READ_PARITY_EN
    .sram_rparity(sram_rparity),
    .io_resp_bits_parityError(io_resp_bits_parityError),
`endif
    .io_resp_valid(io_resp_valid),
    .io_resp_ready(io_resp_ready),
    .io_resp_bits_data(io_resp_bits_data),
    .io_resp_bits_readSource(io_resp_bits_readSource),
    .io_resp_bits_instructionIndex(io_resp_bits_instructionIndex)
  );

`ifndef VRF_READ_PARITY_EN
  assign io_resp_bits_parityError = 1'b0;
`endif

  always #5 clock = ~clock;

  // Fixed-latency SRAM model; flip injects a bad parity bit for a read.
  logic [31:0] mem_model [1024];
  logic [31:0] dpipe [LAT];
  logic        fpipe [LAT];
  logic        flip = 1'b0;
  always @(posedge clock) begin
    dpipe[0] <= sram_en ? mem_model[sram_addr] : 32'h0;
    fpipe[0] <= flip;
    for (int i = 1; i < LAT; i++) begin
      dpipe[i] <= dpipe[i-1];
      fpipe[i] <= fpipe[i-1];
    end
  end
  assign sram_rdata   = dpipe[LAT-1];
  assign sram_rparity = (^sram_rdata) ^ fpipe[LAT-1];

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  src;
    logic [2:0]  idx;
    logic        perr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   pop_count = 0;
  int   acc_count = 0;
  int   pop_cycle [256];

  always @(posedge clock) cycle <= cycle + 1;

  // Monitor: pops and compares on each response fire, records each accept.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      exp_q.delete();
    end else begin
      if (io_resp_valid && io_resp_ready) begin
        pop_cycle[pop_count % 256] = cycle;
        pop_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp got data=%h src=%h idx=%h", io_resp_bits_data,
                   io_resp_bits_readSource, io_resp_bits_instructionIndex);
        end else begin
          e = exp_q.pop_front();
          if (io_resp_bits_data !== e.data || io_resp_bits_readSource !== e.src ||
              io_resp_bits_instructionIndex !== e.idx || io_resp_bits_parityError !== e.perr) begin
            errors++;
            $display("FAIL resp_order got %h/%h/%h/%b want %h/%h/%h/%b", io_resp_bits_data,
                     io_resp_bits_readSource, io_resp_bits_instructionIndex,
                     io_resp_bits_parityError, e.data, e.src, e.idx, e.perr);
          end
        end
      end
      if (io_req_valid && io_req_ready) begin
        e.data = mem_model[sram_addr];
        e.src  = io_req_bits_readSource;
        e.idx  = io_req_bits_instructionIndex;
`ifdef VRF_READ_PARITY_EN
        e.perr = flip;
`else
        e.perr = 1'b0;
`endif
        exp_q.push_back(e);
        acc_count++;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic v, input logic [4:0] vs, input logic [4:0] off,
                     input logic [3:0] src, input logic [2:0] idx);
    io_req_valid                 = v;
    io_req_bits_vs               = vs;
    io_req_bits_offset           = off;
    io_req_bits_readSource       = src;
    io_req_bits_instructionIndex = idx;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, p0, base;
    for (int i = 0; i < 1024; i++) mem_model[i] = 32'hA5000000 + i * 32'h00010003;
    mem_model[10'h065] = 32'hDEADBEEF;
    mem_model[10'h001] = 32'h00000001;

    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("rst_req_ready", 64'(io_req_ready), 64'd1);
    chk("rst_resp_valid", 64'(io_resp_valid), 64'd0);
    chk("rst_sram_en", 64'(sram_en), 64'd0);
    chk("rst_resp_bits", {25'd0, io_resp_bits_readSource, io_resp_bits_instructionIndex,
                          io_resp_bits_data}, 64'd0);

    // Single read: vs=3 off=5 -> addr 0x065, data returns at t2, valid at t3.
    req(1'b1, 5'd3, 5'd5, 4'h2, 3'h6);
    #1;
    chk("t0_sram_en", 64'(sram_en), 64'd1);
    chk("t0_sram_addr", 64'(sram_addr), 64'h065);
    tick();
    req(1'b0, '0, '0, '0, '0);
    #1 chk("t1_resp_valid", 64'(io_resp_valid), 64'd0);
    tick();
    chk("t2_resp_valid", 64'(io_resp_valid), 64'd0);
    tick();
    chk("t3_resp_valid", 64'(io_resp_valid), 64'd1);
    chk("t3_resp_data", 64'(io_resp_bits_data), 64'hDEADBEEF);
    chk("t3_resp_tags", {57'd0, io_resp_bits_readSource, io_resp_bits_instructionIndex},
        {57'd0, 4'h2, 3'h6});
    io_resp_ready = 1'b1;
    tick();

    // Streaming: 16 back-to-back with consumer always ready.
    base = pop_count;
    for (int i = 0; i < 16; i++) begin
      req(1'b1, 5'(i + 8), 5'(i), 4'(i), 3'(i));
      #1 chk("stream_req_ready", 64'(io_req_ready), 64'd1);
      tick();
    end
    req(1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 20 && pop_count < base + 16; i++) tick();
    chk("stream_pops", 64'(pop_count - base), 64'd16);
    chk("stream_consecutive", 64'(pop_cycle[(base + 15) % 256] - pop_cycle[base % 256]), 64'd15);

    // Full backpressure then simultaneous pop + accept at the credit limit.
    io_resp_ready = 1'b0;
    a0 = acc_count;
    for (int i = 0; i < 8; i++) begin
      req(1'b1, 5'd20, 5'(i), 4'(i + 1), 3'(i));
      tick();
    end
    #1;
    chk("bp_accepts", 64'(acc_count - a0), 64'd4);
    chk("bp_req_ready_low", 64'(io_req_ready), 64'd0);
    io_resp_ready = 1'b1;
    #1;
    chk("bp_ready_on_first_pop", 64'(io_req_ready), 64'd1);
    chk("bp_resp_valid", 64'(io_resp_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      req(1'b1, 5'd21, 5'(i), 4'(i + 9), 3'(i + 2));
      #1 chk("full_simul_ready", 64'(io_req_ready), 64'd1);
    end
    tick();
    req(1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("bp_total_accepts", 64'(acc_count - a0), 64'd9);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-flight: one entry queued, two tags in the pipe.
    io_resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req(1'b1, 5'd7, 5'(i), 4'hC, 3'(i));
      tick();
    end
    req(1'b0, '0, '0, '0, '0);
    #1 chk("pre_rst_resp_valid", 64'(io_resp_valid), 64'd1);
    p0 = pop_count;
    reset = 1'b0;
    #1;
    chk("rst_async_resp_valid", 64'(io_resp_valid), 64'd0);
    chk("rst_req_ready_forced", 64'(io_req_ready), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("post_rst_req_ready", 64'(io_req_ready), 64'd1);
    chk("post_rst_resp_valid", 64'(io_resp_valid), 64'd0);
    io_resp_ready = 1'b1;
    repeat (10) tick();
    chk("no_stale_resp", 64'(pop_count - p0), 64'd0);

`ifdef VRF_READ_PARITY_EN
    // data 1 has odd parity: rparity 0 flags an error, rparity 1 does not.
    flip = 1'b1;
    req(1'b1, 5'd0, 5'd1, 4'h9, 3'h1);
    tick();
    req(1'b0, '0, '0, '0, '0);
    flip = 1'b0;
    tick();
    tick();
    chk("par_bad_valid", 64'(io_resp_valid), 64'd1);
    chk("par_bad_data", 64'(io_resp_bits_data), 64'h1);
    chk("par_bad_flag", 64'(io_resp_bits_parityError), 64'd1);
    tick();
    req(1'b1, 5'd0, 5'd1, 4'hA, 3'h2);
    tick();
    req(1'b0, '0, '0, '0, '0);
    tick();
    tick();
    chk("par_good_valid", 64'(io_resp_valid), 64'd1);
    chk("par_good_data", 64'(io_resp_bits_data), 64'h1);
    chk("par_good_flag", 64'(io_resp_bits_parityError), 64'd0);
    tick();
`endif

    repeat (5) tick();
    chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
